// File: rtl/four_bit_mux_pkg.sv
// Shared types and constants for the four_bit_mux_arbiter block.
//   state_t     : arbiter FSM state encoding
//   out_word_t  : payload held in the output register (source index + word)
//   DATA_W      : datapath word width
//   STAT_W      : width of the optional per-requester transfer counters
//   grant_onehot: maps an FSM state onto the one-hot grant vector
package four_bit_mux_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned STAT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic              src;
        logic [DATA_W-1:0] data;
    } out_word_t;

    function automatic logic [1:0] grant_onehot(input state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GRANT0) g = 2'b01;
        if (s == GRANT1) g = 2'b10;
        return g;
    endfunction

endpackage : four_bit_mux_pkg

// File: rtl/four_bit_2x1_mux.sv
// Combinational 4-bit 2:1 multiplexer.
//   a, b : candidate words (a chosen when sel = 0)
//   sel  : select
//   y_c  : selected word (combinational)
module four_bit_2x1_mux
    import four_bit_mux_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y_c
);

    assign y_c = sel ? b : a;

endmodule : four_bit_2x1_mux

// File: rtl/four_bit_mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4-bit 2:1 mux datapath.
// Two valid/ready requesters are granted one at a time, each for at most
// BURST_LEN consecutive transfers, and the selected word is registered into a
// single output stage with its own valid/ready handshake.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in0_valid/data/ready    : requester 0 handshake (ready is combinational)
//   in1_valid/data/ready    : requester 1 handshake (ready is combinational)
//   out_valid/data/src      : registered output word and its requester index
//   out_ready               : consumer accepts out_data
//   grant                   : one-hot current grant, 00 when idle
// Optional: define MUX_ARB_STATS_EN to add xfer_cnt0/xfer_cnt1, saturating
// per-requester transfer counters.
module four_bit_mux_arbiter
    import four_bit_mux_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [1:0]        grant
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] xfer_cnt0,
    output logic [STAT_W-1:0] xfer_cnt1
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  burst_cnt, burst_n;
    logic              last_grant, last_n;
    out_word_t         out_q;
    logic [DATA_W-1:0] mux_y;
    logic              sel, stall, cur_valid, oth_valid, xfer;

    // Datapath select follows the FSM directly.
    assign sel = (state == GRANT1);

    four_bit_2x1_mux u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (sel),
        .y_c (mux_y)
    );

    // A full output register that is not being drained blocks all transfers.
    assign stall     = out_valid && !out_ready;
    assign in0_ready = (state == GRANT0) && !stall;
    assign in1_ready = (state == GRANT1) && !stall;
    assign cur_valid = sel ? in1_valid : in0_valid;
    assign oth_valid = sel ? in0_valid : in1_valid;
    assign xfer      = (state != IDLE) && cur_valid && !stall;

    assign out_data = out_q.data;
    assign out_src  = out_q.src;

    // State, burst counter, last-grant and registered grant vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
        end else begin
            state      <= state_n;
            burst_cnt  <= burst_n;
            last_grant <= last_n;
            grant      <= grant_onehot(state_n);
        end
    end

    // Next-state: round-robin on ties, release on idle requester or full burst.
    always_comb begin
        state_n = state;
        burst_n = burst_cnt;
        last_n  = last_grant;
        case (state)
            IDLE: begin
                burst_n = '0;
                if (in0_valid && in1_valid) begin
                    state_n = last_grant ? GRANT0 : GRANT1;
                end else if (in0_valid) begin
                    state_n = GRANT0;
                end else if (in1_valid) begin
                    state_n = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!cur_valid || (xfer && (burst_cnt == CNT_LAST))) begin
                    burst_n = '0;
                    if (oth_valid) begin
                        state_n = sel ? GRANT0 : GRANT1;
                    end else if (cur_valid) begin
                        state_n = state;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    burst_n = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                burst_n = '0;
            end
        endcase
        if (state_n == GRANT0) last_n = 1'b0;
        if (state_n == GRANT1) last_n = 1'b1;
    end

    // Output stage: a new word always wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_q.data <= mux_y;
            out_q.src  <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Saturating per-requester transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt0 <= '0;
            xfer_cnt1 <= '0;
        end else if (xfer) begin
            if (!sel && (xfer_cnt0 != '1)) xfer_cnt0 <= xfer_cnt0 + STAT_W'(1);
            if (sel && (xfer_cnt1 != '1))  xfer_cnt1 <= xfer_cnt1 + STAT_W'(1);
        end
    end
`endif

endmodule : four_bit_mux_arbiter

// File: tb/tb_four_bit_mux_arbiter.sv
// Self-checking bench for four_bit_mux_arbiter: a transaction-level model
// (current owner, words taken in this grant, last winner, output slot) is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_four_bit_mux_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic [3:0] in0_data = 4'h0, in1_data = 4'h0;
    logic       in0_ready, in1_ready;
    logic       out_valid, out_src;
    logic [3:0] out_data;
    logic       out_ready = 1'b1;
    logic [1:0] grant;
`ifdef MUX_ARB_STATS_EN
    logic [7:0] xfer_cnt0, xfer_cnt1;
`endif

    four_bit_mux_arbiter #(.BURST_LEN(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .grant     (grant)
`ifdef MUX_ARB_STATS_EN
        ,
        .xfer_cnt0 (xfer_cnt0),
        .xfer_cnt1 (xfer_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 none), words taken under current grant, last winner, output slot.
    int         m_owner;
    int         m_taken;
    int         m_last;
    bit         m_ov;
    logic [3:0] m_od;
    bit         m_os;
    int         m_cnt0, m_cnt1;

    task automatic model_reset();
        m_owner = -1; m_taken = 0; m_last = 1;
        m_ov = 0; m_od = 4'h0; m_os = 0;
        m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic model_step();
        bit         v[2];
        logic [3:0] d[2];
        bit         took;
        int         nxt;
        v[0] = in0_valid; v[1] = in1_valid;
        d[0] = in0_data;  d[1] = in1_data;
        took = 0;
        nxt  = m_owner;
        if (m_owner < 0) begin
            if (v[0] && v[1]) nxt = 1 - m_last;
            else if (v[0])    nxt = 0;
            else if (v[1])    nxt = 1;
            m_taken = 0;
        end else begin
            took = v[m_owner] && (!m_ov || out_ready);
            if (!v[m_owner] || (took && (m_taken + 1 == BURST))) begin
                m_taken = 0;
                if (v[1 - m_owner])    nxt = 1 - m_owner;
                else if (v[m_owner])   nxt = m_owner;
                else                   nxt = -1;
            end else if (took) begin
                m_taken++;
            end
        end
        if (took) begin
            m_ov = 1; m_od = d[m_owner]; m_os = (m_owner == 1);
            if (m_owner == 0 && m_cnt0 < 255) m_cnt0++;
            if (m_owner == 1 && m_cnt1 < 255) m_cnt1++;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (nxt >= 0) m_last = nxt;
        m_owner = nxt;
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
        end
    end

    // Per-cycle compare at the falling edge; also records accepted handshakes.
    bit acc0 = 0, acc1 = 0;
    initial begin : compare_proc
        logic [1:0] eg;
        forever begin
            @(negedge clk);
            acc0 = in0_valid && in0_ready;
            acc1 = in1_valid && in1_ready;
            if (rst_n) begin
                eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
                check("grant", 8'(grant), 8'(eg));
                check("in0_ready", 8'(in0_ready), 8'((m_owner == 0) && (!m_ov || out_ready)));
                check("in1_ready", 8'(in1_ready), 8'((m_owner == 1) && (!m_ov || out_ready)));
                check("out_valid", 8'(out_valid), 8'(m_ov));
                check("out_data", 8'(out_data), 8'(m_od));
                check("out_src", 8'(out_src), 8'(m_os));
`ifdef MUX_ARB_STATS_EN
                check("xfer_cnt0", xfer_cnt0, 8'(m_cnt0));
                check("xfer_cnt1", xfer_cnt1, 8'(m_cnt1));
`endif
            end
        end
    end

    // Auto-advancing sources: next word presented after each accepted one.
    bit inc0 = 0, inc1 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (inc0 && acc0) in0_data = in0_data + 4'd1;
        if (inc1 && acc1) in1_data = in1_data + 4'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0;
        inc0 = 0; inc1 = 0; out_ready = 1;
        ticks(2);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        // Reset then idle.
        do_reset();
        ticks(5);
        check("idle grant", 8'(grant), 8'h00);
        check("idle in0_ready", 8'(in0_ready), 8'h00);
        check("idle in1_ready", 8'(in1_ready), 8'h00);
        check("idle out_valid", 8'(out_valid), 8'h00);
        check("idle out_data", 8'(out_data), 8'h00);

        // Single requester with burst re-grant.
        in0_valid = 1; in0_data = 4'h3; inc0 = 1;
        tick();
        check("single grant P1", 8'(grant), 8'h01);
        check("single bubble P1", 8'(out_valid), 8'h00);
        tick();
        check("single first word", 8'(out_data), 8'h03);
        check("single first valid", 8'(out_valid), 8'h01);
        ticks(4);
        check("single regrant word", 8'(out_data), 8'h07);
        check("single regrant grant", 8'(grant), 8'h01);
        ticks(3);
        check("single word P9", 8'(out_data), 8'h0A);
        in0_valid = 0; inc0 = 0;
        tick();
        check("single release idle", 8'(grant), 8'h00);
        check("single drained", 8'(out_valid), 8'h00);
        // Tie after requester 0 last won goes to requester 1.
        in0_valid = 1; in0_data = 4'hE; in1_valid = 1; in1_data = 4'h6;
        tick();
        check("tie after grant0", 8'(grant), 8'h10 >> 3);

        // Contention from reset.
        do_reset();
        in0_valid = 1; in0_data = 4'hA; in1_valid = 1; in1_data = 4'h5;
        tick();
        check("cont grant P1", 8'(grant), 8'h01);
        tick();
        check("cont word0", 8'(out_data), 8'h0A);
        check("cont src0", 8'(out_src), 8'h00);
        ticks(3);
        check("cont switch grant", 8'(grant), 8'h02);
        check("cont last src0", 8'(out_src), 8'h00);
        tick();
        check("cont word1", 8'(out_data), 8'h05);
        check("cont src1", 8'(out_src), 8'h01);
        ticks(3);
        check("cont back grant", 8'(grant), 8'h01);
        tick();
        check("cont src0 again", 8'(out_src), 8'h00);
        check("cont word0 again", 8'(out_data), 8'h0A);

        // Backpressure during GRANT1.
        do_reset();
        in1_valid = 1; in1_data = 4'h1; inc1 = 1;
        ticks(3);
        check("bp before data", 8'(out_data), 8'h02);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp frozen data", 8'(out_data), 8'h02);
            check("bp in1_ready", 8'(in1_ready), 8'h00);
            check("bp grant", 8'(grant), 8'h02);
            check("bp valid", 8'(out_valid), 8'h01);
        end
        out_ready = 1;
        tick();
        check("bp resume data", 8'(out_data), 8'h03);
        check("bp resume valid", 8'(out_valid), 8'h01);

        // Early release to the other requester.
        do_reset();
        in0_valid = 1; in0_data = 4'h1; inc0 = 1;
        in1_valid = 1; in1_data = 4'hC;
        ticks(3);
        check("early word2", 8'(out_data), 8'h02);
        in0_valid = 0; inc0 = 0;
        tick();
        check("early grant", 8'(grant), 8'h02);
        check("early gap", 8'(out_valid), 8'h00);
        tick();
        check("early word1", 8'(out_data), 8'h0C);
        check("early src1", 8'(out_src), 8'h01);

        // Mid-burst reset, then saturation run.
        do_reset();
        in0_valid = 1; in0_data = 4'h9;
        ticks(4);
        check("mid grant before", 8'(grant), 8'h01);
        rst_n = 0;
        model_reset();
        #1;
        check("mid rst grant", 8'(grant), 8'h00);
        check("mid rst in0_ready", 8'(in0_ready), 8'h00);
        check("mid rst in1_ready", 8'(in1_ready), 8'h00);
        check("mid rst out_valid", 8'(out_valid), 8'h00);
        check("mid rst out_data", 8'(out_data), 8'h00);
        check("mid rst out_src", 8'(out_src), 8'h00);
`ifdef MUX_ARB_STATS_EN
        check("mid rst xfer_cnt0", xfer_cnt0, 8'h00);
`endif
        in0_valid = 0;
        ticks(2);
        rst_n = 1;
        in0_valid = 1; in0_data = 4'h1; inc0 = 1;
        ticks(310);
`ifdef MUX_ARB_STATS_EN
        check("sat xfer_cnt0", xfer_cnt0, 8'hFF);
        check("sat xfer_cnt1", xfer_cnt1, 8'h00);
`endif
        check("long run grant", 8'(grant), 8'h01);
        in0_valid = 0;
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_four_bit_mux_arbiter

// File: doc/four_bit_mux_arbiter.md
# four_bit_mux_arbiter

Round-robin arbiter and sequencer for the shared 4-bit 2x1 mux datapath. Two requesters present 4-bit words with valid/ready handshakes. The block grants one requester at a time, drives the mux select, and registers the selected word into a single output stage with its own valid/ready handshake. A per-grant burst limit guarantees fairness under continuous demand.

## Interface
- BURST_LEN, 4: maximum consecutive transfers per grant; legal range 1..15
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0_valid  input  1  requester 0 has a word
- in0_data  input  4  requester 0 word
- in0_ready  output  1  requester 0 word accepted this cycle when high with in0_valid
- in1_valid  input  1  requester 1 has a word
- in1_data  input  4  requester 1 word
- in1_ready  output  1  requester 1 word accepted this cycle when high with in1_valid
- out_valid  output  1  output register holds a word
- out_data  output  4  registered mux output
- out_src  output  1  requester index of out_data
- out_ready  input  1  consumer accepts out_data
- grant  output  2  one-hot current grant; 00 in IDLE

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Mux select = (state == GRANT1).
- last_grant register: holds the index of the most recently granted requester.
- inX_ready = (state == GRANTX) && (!out_valid || out_ready). This is combinational and never depends on inX_valid.
- Transfer X: inX_valid && inX_ready. The mux output is loaded into out_data, out_src = X, out_valid = 1. burst_cnt increments.
- Output drain: out_valid && out_ready && no new transfer → out_valid = 0. out_data holds its value.
- IDLE:
  - If both are valid, grant !last_grant.
  - If only one is valid, grant it.
  - burst_cnt = 0. The grant takes effect next cycle.
- GRANTX releases when:
  - inX_valid is low; or
  - a transfer occurs with burst_cnt == BURST_LEN-1.
- On release, the next state is:
  - GRANT(other) if the other requester is valid;
  - else GRANTX if inX_valid is still high (burst exhausted case);
  - else IDLE.
- burst_cnt is cleared on every grant change and every re-grant. last_grant updates on entry to GRANTX.
- Output stalled (out_valid && !out_ready): the grant is held, no release on burst count, and in*_ready is low. Release on inX_valid low still applies.
- burst_cnt width: 4 bits. It never exceeds BURST_LEN-1.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie), burst_cnt = 0.
  - out_valid = 0, out_data = 0, out_src = 0, grant = 00, in0_ready = in1_ready = 0.
- Arbitration latency: request valid in IDLE → grant visible next cycle → first transfer in that cycle.
- Data latency: 1 cycle from transfer to out_valid/out_data.
- Throughput: 1 word/cycle within a grant. A switch directly from GRANTX to GRANT(other) costs no bubble. Passing through IDLE costs 1 bubble.
- Simultaneous output drain and new transfer in the same cycle: the new word replaces the old, and out_valid stays 1.
- rst_n asserted mid-burst: all state returns to reset values immediately. An in-flight out_data word is dropped.

## Configuration
- MUX_ARB_STATS_EN defined:
  - Adds outputs xfer_cnt0 and xfer_cnt1, each 8 bits.
  - Each counts completed transfers per requester and saturates at 255.
  - Both reset to 0.
- MUX_ARB_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package four_bit_mux_pkg:
  - state enum (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
  - DATA_W=4;
  - STAT_W=8.
- Sub-module: the existing four_bit_2x1_mux is instantiated for the data path, with select driven from the FSM. The output register and FSM are in this block.

## Test plan
- Reset then idle: no valids for 5 cycles → grant=00, in*_ready=0, out_valid=0, out_data=0.
- Single requester: in0_valid=1 continuously with data 0x3, 0x4, …, out_ready=1 → 1-cycle bubble for the initial grant, then 1 word/cycle. out_data follows 0x3, 0x4, …, out_src=0. After every 4 words, burst_cnt reaches BURST_LEN-1 and the release re-grants requester 0 directly with no bubble.
- Contention: both valid from reset, in0 data 0xA, in1 data 0x5, out_ready=1, BURST_LEN=4 → 4 words src 0 (0xA), then 4 words src 1 (0x5), alternating with no bubbles.
- Backpressure: out_ready=0 for 3 cycles during GRANT1 → out_data frozen, in1_ready=0, grant stays 10. When out_ready rises, the next word follows the same cycle.
- Early release: in0 drops valid after 2 words while in1 is valid → next cycle grant=10, and requester 1's first word appears one cycle later.
- Mid-burst reset and stats: pulse rst_n low during GRANT0 → all outputs return to reset values. With MUX_ARB_STATS_EN, xfer_cnt0=0, and after 300 requester-0 transfers xfer_cnt0=255.
